// File: rtl/speaker_envelope.sv
// speaker_envelope
//   Shapes the note sequencer's square-wave tone with an attack / decay /
//   sustain / release amplitude envelope. The envelope level gates the tone
//   through a PWM comparator before it reaches the speaker pin. The block also
//   detects a stalled tone (a rest), supports a level-sensitive mute, and
//   accepts a note-boundary strobe that retriggers the attack phase.
//
// Ports
//   clk          system clock (same domain as the sequencer)
//   rst          asynchronous, active-high reset
//   tone_in      square-wave tone from the sequencer
//   note_start   single-cycle note-boundary strobe
//   mute         level-sensitive mute
//   speaker_pwm  enveloped tone, registered
//   level        current envelope level, registered
//   busy         high whenever the envelope FSM is not IDLE, registered
//
// No valid/ready handshakes exist on this block: every input is sampled
// every cycle and every output is a plain registered level.
module speaker_envelope #(
    parameter int PWM_BITS       = 8,
    parameter int STEP_DIV       = 12000,
    parameter int ATTACK_STEP    = 32,
    parameter int DECAY_STEP     = 4,
    parameter int SUSTAIN_LEVEL  = 160,
    parameter int MAX_LEVEL      = 255,
    parameter int SILENCE_CYCLES = 96000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tone_in,
    input  logic                note_start,
    input  logic                mute,
    output logic                speaker_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SIL_W  = $clog2(SILENCE_CYCLES + 1);

    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SIL_W-1:0]    SIL_LIMIT = SIL_W'(SILENCE_CYCLES);
    // PWM period is 2^PWM_BITS-1 so that the top level value is always on.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);

    localparam logic [PWM_BITS:0]   MAX_EXT   = (PWM_BITS+1)'(MAX_LEVEL);
    localparam logic [PWM_BITS:0]   SUS_EXT   = (PWM_BITS+1)'(SUSTAIN_LEVEL);
    localparam logic [PWM_BITS:0]   ATT_EXT   = (PWM_BITS+1)'(ATTACK_STEP);
    localparam logic [PWM_BITS:0]   DEC_EXT   = (PWM_BITS+1)'(DECAY_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                busy_q;
    logic                pwm_q;
    logic                tone_q, tone_prev_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic [SIL_W-1:0]    sil_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;

    logic                tone_edge;
    logic                step_tick;
    logic                silent;

    logic [PWM_BITS:0]   lvl_up;
    logic [PWM_BITS:0]   lvl_dn;
    logic [PWM_BITS-1:0] attack_lvl;
    logic [PWM_BITS-1:0] decay_lvl;
    logic [PWM_BITS-1:0] release_lvl;

    assign tone_edge = tone_q ^ tone_prev_q;
    assign step_tick = (step_cnt_q == STEP_LAST);
    assign silent    = (sil_cnt_q == SIL_LIMIT);

    // Saturating level arithmetic in one extra bit: overflow of the add shows
    // up as a value above MAX, underflow of the subtract sets the top bit.
    always_comb begin
        lvl_up = {1'b0, level_q} + ATT_EXT;
        lvl_dn = {1'b0, level_q} - DEC_EXT;

        attack_lvl = (lvl_up >= MAX_EXT) ? MAX_EXT[PWM_BITS-1:0]
                                         : lvl_up[PWM_BITS-1:0];

        decay_lvl  = (lvl_dn[PWM_BITS] || (lvl_dn < SUS_EXT)) ? SUS_EXT[PWM_BITS-1:0]
                                                               : lvl_dn[PWM_BITS-1:0];

        release_lvl = lvl_dn[PWM_BITS] ? '0 : lvl_dn[PWM_BITS-1:0];
    end

    // Event priority: an unmuted note_start wins everything; RELEASE keeps
    // decaying under mute or silence; mute/silence push active states into
    // RELEASE; otherwise the per-state step logic runs.
    always_comb begin
        state_d = state_q;
        level_d = level_q;

        if (!mute && note_start) begin
            // Retrigger continues from the current level.
            state_d = S_ATTACK;
        end else if (state_q == S_RELEASE) begin
            if (step_tick) begin
                level_d = release_lvl;
                if (release_lvl == '0) begin
                    state_d = S_IDLE;
                end
            end
        end else if (mute) begin
            if (state_q != S_IDLE) begin
                state_d = S_RELEASE;
            end
        end else if (silent && (state_q != S_IDLE)) begin
            state_d = S_RELEASE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tone_edge) begin
                        state_d = S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (step_tick) begin
                        level_d = attack_lvl;
                        if ({1'b0, attack_lvl} == MAX_EXT) begin
                            state_d = S_DECAY;
                        end
                    end
                end
                S_DECAY: begin
                    if (step_tick) begin
                        level_d = decay_lvl;
                        if ({1'b0, decay_lvl} == SUS_EXT) begin
                            state_d = S_SUSTAIN;
                        end
                    end
                end
                S_SUSTAIN: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            busy_q      <= 1'b0;
            pwm_q       <= 1'b0;
            tone_q      <= 1'b0;
            tone_prev_q <= 1'b0;
            step_cnt_q  <= '0;
            sil_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            busy_q      <= (state_d != S_IDLE);
            tone_q      <= tone_in;
            tone_prev_q <= tone_q;

            // Free-running; state changes never realign the step grid.
            step_cnt_q  <= step_tick ? '0 : step_cnt_q + STEP_W'(1);

            if (tone_edge) begin
                sil_cnt_q <= '0;
            end else if (!silent) begin
                sil_cnt_q <= sil_cnt_q + SIL_W'(1);
            end

            pwm_cnt_q   <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);

            pwm_q       <= tone_q & (pwm_cnt_q < level_q) & ~mute;
        end
    end

    assign speaker_pwm = pwm_q;
    assign level       = level_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_speaker_envelope.sv
module tb_speaker_envelope;

    logic       clk;
    logic       rst;
    logic       tone_in;
    logic       note_start;
    logic       mute;
    logic       speaker_pwm;
    logic [7:0] level;
    logic       busy;

    // Second instance with a long silence window so the tone can be held
    // high for a full PWM period while the envelope sits in SUSTAIN.
    logic       tone2;
    logic       note2;
    logic       mute2;
    logic       pwm2;
    logic [7:0] level2;
    logic       busy2;

    int total;
    int bad;
    bit tone_en;
    int tone_cnt;

    speaker_envelope #(
        .PWM_BITS(8), .STEP_DIV(4), .ATTACK_STEP(64), .DECAY_STEP(16),
        .SUSTAIN_LEVEL(128), .MAX_LEVEL(255), .SILENCE_CYCLES(50)
    ) u_dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .note_start(note_start),
        .mute(mute), .speaker_pwm(speaker_pwm), .level(level), .busy(busy)
    );

    speaker_envelope #(
        .PWM_BITS(8), .STEP_DIV(4), .ATTACK_STEP(64), .DECAY_STEP(16),
        .SUSTAIN_LEVEL(128), .MAX_LEVEL(255), .SILENCE_CYCLES(4000)
    ) u_dut_long (
        .clk(clk), .rst(rst), .tone_in(tone2), .note_start(note2),
        .mute(mute2), .speaker_pwm(pwm2), .level(level2), .busy(busy2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge; the tone generator toggles tone_in
    // every 10 cycles while enabled.
    task automatic cyc();
        @(negedge clk);
        if (tone_en) begin
            tone_cnt++;
            if (tone_cnt >= 10) begin
                tone_cnt = 0;
                tone_in  = ~tone_in;
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        tone_in    = 1'b0;
        note_start = 1'b0;
        mute       = 1'b0;
        tone_en    = 1'b0;
        tone_cnt   = 0;
        tone2      = 1'b0;
        note2      = 1'b0;
        mute2      = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic start_note();
        note_start = 1'b1;
        tone_en    = 1'b1;
        tone_cnt   = 0;
        cyc();
        note_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b1;
        tone_in    = 1'b0;
        note_start = 1'b0;
        mute       = 1'b0;
        tone2      = 1'b0;
        note2      = 1'b0;
        mute2      = 1'b0;
        repeat (3) cyc();
        total++;
        if (level !== 8'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (speaker_pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b want=0", speaker_pwm); end
        total++;
        if (level2 !== 8'd0 || busy2 !== 1'b0) begin
            bad++; $display("FAIL reset_inst2 level=%0d busy=%b want=0/0", level2, busy2);
        end
        rst = 1'b0;
        repeat (5) cyc();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_attack_decay();
        logic [7:0] exp_lv [12] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd239, 8'd223,
                                    8'd207, 8'd191, 8'd175, 8'd159, 8'd143, 8'd128};
        logic [7:0] prev;
        int idx;
        do_reset();
        start_note();
        prev = level;
        idx  = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL ad_busy cycle=%0d got=%b want=1", i, busy); end
            if (level !== prev) begin
                total++;
                if (idx >= 12) begin
                    bad++; $display("FAIL ad_extra_step got=%0d want=no change", level);
                end else if (level !== exp_lv[idx]) begin
                    bad++; $display("FAIL ad_step%0d got=%0d want=%0d", idx, level, exp_lv[idx]);
                end
                idx++;
                prev = level;
            end
        end
        total++;
        if (idx != 12) begin bad++; $display("FAIL ad_step_count got=%0d want=12", idx); end
        total++;
        if (level !== 8'd128) begin bad++; $display("FAIL ad_sustain got=%0d want=128", level); end
    endtask

    // Runs straight after test_attack_decay, starting in SUSTAIN.
    task automatic test_silence();
        logic [7:0] exp_lv [8] = '{8'd112, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd16, 8'd0};
        logic [7:0] prev;
        int idx;
        tone_en = 1'b0;
        prev = level;
        idx  = 0;
        for (int i = 0; i < 120; i++) begin
            cyc();
            if (level !== prev) begin
                total++;
                if (idx >= 8) begin
                    bad++; $display("FAIL sil_extra_step got=%0d want=no change", level);
                end else if (level !== exp_lv[idx]) begin
                    bad++; $display("FAIL sil_step%0d got=%0d want=%0d", idx, level, exp_lv[idx]);
                end
                idx++;
                prev = level;
            end
        end
        total++;
        if (idx != 8) begin bad++; $display("FAIL sil_step_count got=%0d want=8", idx); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL sil_idle_busy got=%b want=0", busy); end
        total++;
        if (level !== 8'd0) begin bad++; $display("FAIL sil_idle_level got=%0d want=0", level); end
    endtask

    task automatic test_mute();
        logic [7:0] exp_lv [8] = '{8'd112, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd16, 8'd0};
        logic [7:0] prev;
        int idx;
        do_reset();
        start_note();
        repeat (80) cyc();
        total++;
        if (level !== 8'd128) begin bad++; $display("FAIL mute_pre_level got=%0d want=128", level); end
        mute = 1'b1;
        cyc();
        total++;
        if (speaker_pwm !== 1'b0) begin bad++; $display("FAIL mute_pwm_first got=%b want=0", speaker_pwm); end
        prev = level;
        idx  = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            total++;
            if (speaker_pwm !== 1'b0) begin bad++; $display("FAIL mute_pwm cycle=%0d got=%b want=0", i, speaker_pwm); end
            if (level !== prev) begin
                total++;
                if (idx >= 8) begin
                    bad++; $display("FAIL mute_extra_step got=%0d want=no change", level);
                end else if (level !== exp_lv[idx]) begin
                    bad++; $display("FAIL mute_step%0d got=%0d want=%0d", idx, level, exp_lv[idx]);
                end
                idx++;
                prev = level;
            end
            if (i == 10) note_start = 1'b1;
            if (i == 11) note_start = 1'b0;
            if (i == 13) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL mute_release_busy got=%b want=1", busy); end
            end
        end
        total++;
        if (idx != 8) begin bad++; $display("FAIL mute_step_count got=%0d want=8", idx); end
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL mute_idle_busy cycle=%0d got=%b want=0", i, busy); end
        end
        mute = 1'b0;
    endtask

    task automatic test_pwm_duty();
        int highs;
        do_reset();
        tone2 = 1'b1;
        repeat (80) cyc();
        total++;
        if (level2 !== 8'd128) begin bad++; $display("FAIL duty_level got=%0d want=128", level2); end
        total++;
        if (busy2 !== 1'b1) begin bad++; $display("FAIL duty_busy got=%b want=1", busy2); end
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (pwm2 === 1'b1) highs++;
        end
        total++;
        if (highs != 128) begin bad++; $display("FAIL duty_high_count got=%0d want=128", highs); end
        tone2 = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (pwm2 !== 1'b0) begin bad++; $display("FAIL duty_tone_low cycle=%0d got=%b want=0", i, pwm2); end
        end
    endtask

    task automatic test_retrigger();
        logic [7:0] exp_lv [3] = '{8'd144, 8'd208, 8'd255};
        logic [7:0] prev;
        int idx;
        bit found;
        do_reset();
        start_note();
        repeat (80) cyc();
        tone_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 150 && !found; i++) begin
            cyc();
            if (level === 8'd80) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL retrig_reach80 got=%0d want=80", level); end
        // An edge first so the saturated silence counter clears alongside
        // the retrigger.
        tone_in = ~tone_in;
        cyc();
        note_start = 1'b1;
        cyc();
        note_start = 1'b0;
        tone_en    = 1'b1;
        tone_cnt   = 0;
        total++;
        if (level !== 8'd80) begin bad++; $display("FAIL retrig_hold got=%0d want=80", level); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL retrig_busy got=%b want=1", busy); end
        prev = level;
        idx  = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (level !== prev) begin
                if (idx < 3) begin
                    total++;
                    if (level !== exp_lv[idx]) begin
                        bad++; $display("FAIL retrig_step%0d got=%0d want=%0d", idx, level, exp_lv[idx]);
                    end
                end
                idx++;
                prev = level;
            end
        end
        total++;
        if (idx < 3) begin bad++; $display("FAIL retrig_step_count got=%0d want>=3", idx); end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        start_note();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (level === 8'd128) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL arst_reach128 got=%0d want=128", level); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (level !== 8'd0) begin bad++; $display("FAIL arst_level got=%0d want=0", level); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        total++;
        if (speaker_pwm !== 1'b0) begin bad++; $display("FAIL arst_pwm got=%b want=0", speaker_pwm); end
        tone_en = 1'b0;
        tone_in = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            total++;
            if (busy !== 1'b0 || level !== 8'd0) begin
                bad++; $display("FAIL arst_stay_idle cycle=%0d busy=%b level=%0d want=0/0", i, busy, level);
            end
        end
        note_start = 1'b1;
        cyc();
        note_start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL arst_restart_busy got=%b want=1", busy); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total    = 0;
        bad      = 0;
        tone_en  = 1'b0;
        tone_cnt = 0;
        test_reset();
        test_attack_decay();
        test_silence();
        test_mute();
        test_pwm_duty();
        test_retrigger();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speaker_envelope.md
Name: speaker_envelope

Overview:
Downstream stage of the note sequencer. It takes the sequencer's registered square-wave tone (speaker_out) and applies a PWM amplitude envelope before the tone reaches the speaker pin. The envelope has attack, decay, sustain and release phases, so notes no longer start and stop with hard clicks. It also detects silence (a stalled tone), provides a mute, and accepts a note-boundary strobe for retriggering.

Parameters:
PWM_BITS, 8, width of envelope level and PWM counter.
STEP_DIV, 12000, clk cycles per envelope step (1 ms at 12 MHz).
ATTACK_STEP, 32, level increment per step in ATTACK.
DECAY_STEP, 4, level decrement per step in DECAY and RELEASE.
SUSTAIN_LEVEL, 160, level held in SUSTAIN.
MAX_LEVEL, 255, attack peak; must be <= 2^PWM_BITS-1 and > SUSTAIN_LEVEL.
SILENCE_CYCLES, 96000, cycles with no tone_in edge that count as a rest (8 ms; longer than the lowest tone period).

Ports:
clk  input  1  system clock, 12 MHz; same domain as the sequencer.
rst  input  1  reset, asynchronous, active-high.
tone_in  input  1  square-wave tone from the sequencer's speaker_out.
note_start  input  1  single-cycle strobe marking a note boundary.
mute  input  1  level-sensitive mute.
speaker_pwm  output  1  enveloped tone to the speaker pin, registered.
level  output  PWM_BITS  current envelope level, registered.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous): state IDLE; level, speaker_pwm, busy = 0; all counters and tone_q = 0. Asserting rst mid-note clears everything immediately.
- tone_q: tone_in registered once. edge = tone_q XOR the previous tone_q.
- Step prescaler: free-running counter over 0..STEP_DIV-1. step_tick fires when the counter equals STEP_DIV-1. It is never reset by state changes, so the first step after a transition comes 1..STEP_DIV cycles later.
- Silence counter: cleared on edge; otherwise increments, saturating at SILENCE_CYCLES. silent = (count == SILENCE_CYCLES).
- PWM counter: free-running over 0..2^PWM_BITS-2 (period 255 by default). Level MAX = 255 is therefore always on.
- speaker_pwm <= tone_q AND (pwm_cnt < level) AND NOT mute. Latency tone_in -> speaker_pwm is 2 cycles.
- Level arithmetic uses a PWM_BITS+1 intermediate and saturates:
  - ATTACK: min(level+ATTACK_STEP, MAX_LEVEL).
  - DECAY: max(level-DECAY_STEP, SUSTAIN_LEVEL).
  - RELEASE: max(level-DECAY_STEP, 0).
- Level changes only on step_tick.
- FSM (priority for same-cycle events: mute > note_start > silent > step logic):
  - IDLE: note_start, or an edge while not muted -> ATTACK.
  - ATTACK: level reaches MAX_LEVEL -> DECAY.
  - DECAY: level reaches SUSTAIN_LEVEL -> SUSTAIN.
  - SUSTAIN: level held.
  - RELEASE: level reaches 0 -> IDLE.
  - Any non-IDLE state: silent -> RELEASE. If already in RELEASE, it stays there.
  - Any state: note_start while not muted -> ATTACK, continuing from the current level (retrigger; no drop to 0).
  - mute high: speaker_pwm is 0 from the next edge. The state goes to RELEASE (IDLE stays IDLE). note_start and edges are ignored while mute is high.
- busy is registered alongside the state, so it has the same timing as state.

Test Plan:
All scenarios use these overrides: STEP_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, SUSTAIN_LEVEL=128, MAX_LEVEL=255, SILENCE_CYCLES=50. tone_in toggles every 10 cycles unless stated.
1. Attack/decay: note_start pulse -> level steps 64, 128, 192, 255 on successive step_ticks, then 239, 223, ... down to 128, and holds at 128 (SUSTAIN); busy = 1 throughout.
2. Silence: from SUSTAIN, hold tone_in constant for 50 cycles -> RELEASE; level 112, 96, ... 0 per tick; then IDLE and busy = 0.
3. Mute: assert mute in SUSTAIN -> speaker_pwm = 0 on the next edge; level decays to 0. A note_start while muted leaves the state in RELEASE.
4. PWM duty: level = 128, tone_q held high in a phase -> over one 255-cycle PWM window, speaker_pwm is high exactly 128 cycles. When tone_q is low, speaker_pwm = 0.
5. Retrigger: note_start during RELEASE at level 80 -> ATTACK; level goes 144, 208, 255.
6. Async reset: assert rst mid-ATTACK, between clock edges -> level, speaker_pwm and busy read 0 before the next clk edge. After release, the block stays IDLE until a stimulus arrives.
